// File: rtl/instr_encode_pkg.sv
// Shared command codes, MIPS opcode/funct constants and field-packing helpers
// used by the instruction encoder and the decoder.
package instr_encode_pkg;

    typedef enum logic [3:0] {
        CMD_ADD  = 4'd0,
        CMD_SUB  = 4'd1,
        CMD_SLT  = 4'd2,
        CMD_JR   = 4'd3,
        CMD_LW   = 4'd4,
        CMD_SW   = 4'd5,
        CMD_BEQ  = 4'd6,
        CMD_BNE  = 4'd7,
        CMD_XORI = 4'd8,
        CMD_ADDI = 4'd9,
        CMD_J    = 4'd10,
        CMD_JAL  = 4'd11
    } cmd_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_XORI    = 6'h0e;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_JR  = 6'h08;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {OP_SPECIAL, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

endpackage

// File: rtl/instr_encode_pack.sv
// Combinational field packer: command plus register/immediate/jump fields
// in, 32-bit instruction word and a legal flag out.
module instr_pack
    import instr_encode_pkg::*;
(
    input  logic [3:0]  i_cmd,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rs,
    input  logic [15:0] i_imm,
    input  logic [27:0] i_jaddr,
    output logic [31:0] o_word,
    output logic        o_legal
);

    always_comb begin
        o_word  = '0;
        o_legal = 1'b1;
        case (i_cmd)
            CMD_ADD:  o_word = enc_r(i_rs, i_rt, i_rd, FN_ADD);
            CMD_SUB:  o_word = enc_r(i_rs, i_rt, i_rd, FN_SUB);
            CMD_SLT:  o_word = enc_r(i_rs, i_rt, i_rd, FN_SLT);
            CMD_JR:   o_word = enc_r(i_rs, 5'd0, 5'd0, FN_JR);
            CMD_LW:   o_word = enc_i(OP_LW,   i_rs, i_rt, i_imm);
            CMD_SW:   o_word = enc_i(OP_SW,   i_rs, i_rt, i_imm);
            CMD_BEQ:  o_word = enc_i(OP_BEQ,  i_rs, i_rt, i_imm);
            CMD_BNE:  o_word = enc_i(OP_BNE,  i_rs, i_rt, i_imm);
            CMD_XORI: o_word = enc_i(OP_XORI, i_rs, i_rt, i_imm);
            CMD_ADDI: o_word = enc_i(OP_ADDI, i_rs, i_rt, i_imm);
            // Jump targets are byte addresses; a non word-aligned target cannot be encoded.
            CMD_J: begin
                o_word  = enc_j(OP_J, i_jaddr[27:2]);
                o_legal = (i_jaddr[1:0] == 2'b00);
            end
            CMD_JAL: begin
                o_word  = enc_j(OP_JAL, i_jaddr[27:2]);
                o_legal = (i_jaddr[1:0] == 2'b00);
            end
            default:  o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encode.sv
// Instruction encoder: accepts commands, emits one encoded word per accept
// with an auto-incrementing word address for the instruction-memory writer.
module instr_encode
    import instr_encode_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        cmd,
    input  logic [4:0]        rd,
    input  logic [4:0]        rt,
    input  logic [4:0]        rs,
    input  logic [15:0]       imm,
    input  logic [27:0]       jAddr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    input  logic              err_clr
);

    logic [31:0] w_word;
    logic        w_legal;
    logic        w_accept;
    logic        w_drain;

    state_e            r_state;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_addr;
    logic              r_err;

    instr_pack u_pack (
        .i_cmd   (cmd),
        .i_rd    (rd),
        .i_rt    (rt),
        .i_rs    (rs),
        .i_imm   (imm),
        .i_jaddr (jAddr),
        .o_word  (w_word),
        .o_legal (w_legal)
    );

    assign out_valid = (r_state == ST_FULL);
    assign out_instr = r_instr;
    assign out_addr  = r_addr;
    assign err       = r_err;

    assign in_ready = (!out_valid || out_ready) && !restart;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_instr <= '0;
            r_addr  <= BASE_ADDR;
            r_err   <= 1'b0;
        end else begin
            if (restart) begin
                r_state <= ST_EMPTY;
                r_addr  <= BASE_ADDR;
            end else begin
                if (w_drain)
                    r_addr <= r_addr + ADDR_W'(1);
                if (w_accept && w_legal) begin
                    r_state <= ST_FULL;
                    r_instr <= w_word;
                end else if (w_drain) begin
                    r_state <= ST_EMPTY;
                end
            end
            // A new illegal accept wins over a simultaneous clear.
            if (w_accept && !w_legal)
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encode.sv
// Self-checking bench for instr_encode: directed vector table, hand-written
// stall/restart/error/reset sequences, and randomized traffic against a model.
module tb_instr_encode;
    import instr_encode_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, restart, in_valid, out_ready, err_clr;
    logic        in_ready, out_valid, err;
    logic [3:0]  cmd;
    logic [4:0]  rd, rt, rs;
    logic [15:0] imm;
    logic [27:0] jAddr;
    logic [31:0] out_instr;
    logic [9:0]  out_addr;

    logic        in_valid2, out_ready2, in_ready2, out_valid2, err2;
    logic [31:0] out_instr2;
    logic [1:0]  out_addr2;

    always #5 clk = ~clk;

    instr_encode #(.ADDR_W(10), .BASE_ADDR(10'd0)) u_dut (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid), .in_ready(in_ready),
        .cmd(cmd), .rd(rd), .rt(rt), .rs(rs), .imm(imm), .jAddr(jAddr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .err(err), .err_clr(err_clr)
    );

    instr_encode #(.ADDR_W(2), .BASE_ADDR(2'd0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .restart(restart),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .cmd(cmd), .rd(rd), .rt(rt), .rs(rs), .imm(imm), .jAddr(jAddr),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_instr(out_instr2), .out_addr(out_addr2),
        .err(err2), .err_clr(err_clr)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference encoding table indexed by command code; kind 0=R, 1=JR, 2=I, 3=J.
    int op_t[12]   = '{0, 0, 0, 0, 'h23, 'h2b, 'h04, 'h05, 'h0e, 'h08, 'h02, 'h03};
    int fn_t[12]   = '{'h20, 'h22, 'h2a, 'h08, 0, 0, 0, 0, 0, 0, 0, 0};
    int kind_t[12] = '{0, 0, 0, 1, 2, 2, 2, 2, 2, 2, 3, 3};

    bit          m_full;
    logic [31:0] m_word;
    int          m_addr;
    bit          m_err;

    typedef struct {
        logic [3:0]  c;
        logic [4:0]  s, t, d;
        logic [15:0] im;
        logic [27:0] ja;
        logic [31:0] instr;
        logic        legal;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else
            n_pass++;
    endtask

    function automatic void ref_enc(input logic [3:0] c, input logic [4:0] s, input logic [4:0] t,
                                    input logic [4:0] d, input logic [15:0] im, input logic [27:0] ja,
                                    output logic [31:0] w, output bit ok);
        int k;
        k  = int'(c);
        w  = 0;
        ok = 1;
        if (k > 11) begin
            ok = 0;
        end else begin
            case (kind_t[k])
                0: w = (op_t[k] << 26) + (32'(s) << 21) + (32'(t) << 16) + (32'(d) << 11) + fn_t[k];
                1: w = (op_t[k] << 26) + (32'(s) << 21) + fn_t[k];
                2: w = (op_t[k] << 26) + (32'(s) << 21) + (32'(t) << 16) + 32'(im);
                default: begin
                    ok = (ja % 4 == 0);
                    w  = (op_t[k] << 26) + 32'(ja / 4);
                end
            endcase
        end
    endfunction

    task automatic model_reset();
        m_full = 0;
        m_word = 0;
        m_addr = 0;
        m_err  = 0;
    endtask

    // One clock with the currently driven inputs; checks in_ready before the
    // edge and every output against the model after it.
    task automatic tick(input string tag);
        logic [31:0] w;
        bit ok, rdy, acc, drain;
        #1;
        rdy = (!m_full || out_ready) && !restart;
        chk({tag, ".in_ready"}, in_ready, rdy);
        ref_enc(cmd, rs, rt, rd, imm, jAddr, w, ok);
        acc   = in_valid && rdy;
        drain = m_full && out_ready;
        @(posedge clk);
        #1;
        if (restart) begin
            m_full = 0;
            m_addr = 0;
        end else begin
            if (drain) m_addr = (m_addr + 1) % 1024;
            if (acc && ok) begin
                m_full = 1;
                m_word = w;
            end else if (drain) begin
                m_full = 0;
            end
        end
        if (acc && !ok) m_err = 1;
        else if (err_clr) m_err = 0;
        chk({tag, ".out_valid"}, out_valid, m_full);
        chk({tag, ".out_addr"}, out_addr, m_addr);
        chk({tag, ".err"}, err, m_err);
        if (m_full) chk({tag, ".out_instr"}, out_instr, m_word);
    endtask

    task automatic drive(input logic [3:0] c, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] im, input logic [27:0] ja);
        cmd = c; rs = s; rt = t; rd = d; imm = im; jAddr = ja;
    endtask

    initial begin
        logic [31:0] saved;
        int nleg;

        tbl[0]  = '{CMD_ADD,  5'd1,  5'd2,  5'd3, 16'h0000, 28'h0, 32'h00221820, 1'b1};
        tbl[1]  = '{CMD_SUB,  5'd4,  5'd5,  5'd6, 16'h1234, 28'h0, 32'h00853022, 1'b1};
        tbl[2]  = '{CMD_SLT,  5'd31, 5'd0,  5'd31, 16'h0000, 28'h0, 32'h03E0F82A, 1'b1};
        tbl[3]  = '{CMD_JR,   5'd31, 5'd7,  5'd9, 16'hFFFF, 28'h0, 32'h03E00008, 1'b1};
        tbl[4]  = '{CMD_LW,   5'd29, 5'd8,  5'd0, 16'hFFFC, 28'h0, 32'h8FA8FFFC, 1'b1};
        tbl[5]  = '{CMD_SW,   5'd29, 5'd31, 5'd0, 16'h0010, 28'h0, 32'hAFBF0010, 1'b1};
        tbl[6]  = '{CMD_BEQ,  5'd1,  5'd2,  5'd0, 16'hFFFF, 28'h0, 32'h1022FFFF, 1'b1};
        tbl[7]  = '{CMD_BNE,  5'd0,  5'd0,  5'd0, 16'h0005, 28'h0, 32'h14000005, 1'b1};
        tbl[8]  = '{CMD_XORI, 5'd3,  5'd4,  5'd0, 16'h00FF, 28'h0, 32'h386400FF, 1'b1};
        tbl[9]  = '{CMD_ADDI, 5'd2,  5'd2,  5'd0, 16'h8000, 28'h0, 32'h20428000, 1'b1};
        tbl[10] = '{CMD_J,    5'd0,  5'd0,  5'd0, 16'h0000, 28'h0000040, 32'h08000010, 1'b1};
        tbl[11] = '{CMD_JAL,  5'd0,  5'd0,  5'd0, 16'h0000, 28'hFFFFFFC, 32'h0FFFFFFF, 1'b1};
        tbl[12] = '{4'hF,     5'd1,  5'd2,  5'd3, 16'h0000, 28'h0, 32'h0, 1'b0};
        tbl[13] = '{CMD_J,    5'd0,  5'd0,  5'd0, 16'h0000, 28'h0000002, 32'h0, 1'b0};

        rst_n = 0; restart = 0; in_valid = 0; out_ready = 1; err_clr = 0;
        in_valid2 = 0; out_ready2 = 1;
        drive(CMD_ADD, 0, 0, 0, 0, 0);
        model_reset();
        #3;
        chk("reset.out_valid", out_valid, 0);
        chk("reset.out_instr", out_instr, 0);
        chk("reset.out_addr", out_addr, 0);
        chk("reset.err", err, 0);
        #9 rst_n = 1;
        @(posedge clk); #1;

        // Directed table, back-to-back with out_ready high.
        nleg = 0;
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].c, tbl[i].s, tbl[i].t, tbl[i].d, tbl[i].im, tbl[i].ja);
            in_valid = 1;
            tick("tbl");
            chk("tbl.valid", out_valid, tbl[i].legal);
            if (tbl[i].legal) begin
                chk("tbl.instr", out_instr, tbl[i].instr);
                chk("tbl.addr", out_addr, nleg);
                nleg++;
            end
        end
        chk("illegal.err", err, 1);

        // Sticky error, clear, and clear colliding with a new illegal accept.
        in_valid = 0;
        for (int i = 0; i < 3; i++) tick("err_hold");
        chk("err.hold", err, 1);
        err_clr = 1;
        tick("err_clr");
        chk("err.cleared", err, 0);
        drive(4'hF, 0, 0, 0, 0, 0);
        in_valid = 1;
        tick("err_collide");
        chk("err.collide", err, 1);
        in_valid = 0;
        tick("err_clr2");
        err_clr = 0;

        // Stall: word held while out_ready low for 3 cycles.
        drive(CMD_ADD, 5'd7, 5'd8, 5'd9, 0, 0);
        in_valid = 1; out_ready = 0;
        tick("stall_load");
        saved = out_instr;
        drive(CMD_SUB, 5'd1, 5'd1, 5'd1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("stall.in_ready", in_ready, 0);
            tick("stall");
            chk("stall.instr", out_instr, saved);
        end

        // Restart while FULL with out_ready low.
        restart = 1;
        tick("restart");
        chk("restart.valid", out_valid, 0);
        restart = 0;
        drive(CMD_LW, 5'd29, 5'd8, 0, 16'hFFFC, 0);
        out_ready = 1;
        tick("after_restart");
        chk("restart.addr", out_addr, 0);
        chk("restart.instr", out_instr, 32'h8FA8FFFC);

        // Five back-to-back words from a fresh restart.
        in_valid = 0;
        restart = 1;
        tick("restart2");
        restart = 0;
        in_valid = 1;
        drive(CMD_ADD, 5'd1, 5'd2, 5'd3, 0, 0);
        for (int k = 0; k < 5; k++) begin
            tick("b2b");
            chk("b2b.addr", out_addr, k);
        end
        in_valid = 0;
        tick("b2b_drain");

        // Narrow address wrap on the ADDR_W=2 instance.
        in_valid2 = 1;
        for (int k = 0; k < 5; k++) begin
            tick("wrap_idle");
            chk("wrap.valid", out_valid2, 1);
            chk("wrap.addr", out_addr2, k % 4);
        end
        in_valid2 = 0;

        // Async reset mid-transfer drops the held word.
        drive(CMD_XORI, 5'd3, 5'd4, 0, 16'h00FF, 0);
        in_valid = 1; out_ready = 0;
        tick("pre_reset");
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("midrst.valid", out_valid, 0);
        chk("midrst.instr", out_instr, 0);
        chk("midrst.addr", out_addr, 0);
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        rst_n = 1;
        tick("post_reset");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [27:0] ja;
            ja = 28'($urandom);
            if ($urandom_range(0, 4) != 0) ja[1:0] = 2'b00;
            drive(($urandom_range(0, 5) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11)),
                  5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), ja);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) != 0);
            restart   = ($urandom_range(0, 24) == 0);
            err_clr   = ($urandom_range(0, 9) == 0);
            tick("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
